move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter NUM_POS, default 9, number of board cells.
REQ-002 Parameter SEL_W, default 4, width of cell-select input.
REQ-003 clock  in  1  the only clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 play  in  1  move request strobe, sampled only in IDLE.
REQ-006 pos_sel  in  SEL_W  requested cell, 1..9 legal, 0 and 10..15 illegal.
REQ-007 pos1..pos9  in  2 each  current board cells: 00 empty, 01 player, 10 computer.
REQ-008 win  in  1  combinational winner flag from the winner-detect stage.
REQ-009 ply_En_pos  out  NUM_POS  one-hot cell write enable to the position registers.
REQ-010 XO_turn  out  1  turn: 1 writes 01 (player), 0 writes 10 (computer).
REQ-011 illegal_move  out  1  rejected-request pulse; also blocks position-register writes.
REQ-012 game_over  out  1  sticky end-of-game flag.
REQ-013 move_count  out  4  accepted moves since reset, 0..9.

Function
REQ-014 FSM states SHALL be IDLE, CHECK, COMMIT, UPDATE, ILLEGAL, OVER; all outputs SHALL be registered (Moore).
REQ-015 IDLE: play=1 at edge t SHALL latch pos_sel and go to CHECK; play=0 stays IDLE.
REQ-016 CHECK: latched sel outside 1..9 or addressed cell != 00 SHALL go to ILLEGAL; otherwise COMMIT.
REQ-017 ILLEGAL SHALL last exactly one cycle with illegal_move=1, ply_En_pos=0, then return to IDLE; XO_turn and move_count unchanged.
REQ-018 COMMIT SHALL last exactly one cycle with ply_En_pos = one-hot bit (sel-1), illegal_move=0; ply_En_pos SHALL be 0 in every other state.
REQ-019 UPDATE SHALL last one cycle; at its closing edge move_count increments, XO_turn toggles, and next state is OVER if win=1 or new move_count=9, else IDLE.
REQ-020 Latency: play sampled at edge t -> ply_En_pos high between edges t+2 and t+3 -> XO_turn toggles at edge t+4.
REQ-021 XO_turn SHALL be stable from CHECK through COMMIT.
REQ-022 play asserted outside IDLE SHALL be ignored and not queued.
REQ-023 OVER: game_over=1, all play ignored, state held until reset.
REQ-024 win=1 sampled in IDLE (external board change) SHALL force OVER at next edge.
REQ-025 move_count SHALL saturate at 9, never wrap.

Reset
REQ-026 On reset: state IDLE, ply_En_pos 0, XO_turn 1, illegal_move 0, game_over 0, move_count 0, latched sel 0.
REQ-027 Reset asserted mid-move (CHECK/COMMIT/UPDATE) SHALL abort the move with no count or turn change surviving.
REQ-028 First play after reset deassertion SHALL be accepted at the first clock edge in IDLE.

Structure
REQ-029 Shared package ttt_pkg SHALL hold the state enum, cell encodings CELL_EMPTY=00, CELL_PLAYER=01, CELL_COMP=10, and NUM_POS.
REQ-030 Sub-module pos_decoder SHALL map SEL_W select to NUM_POS one-hot plus a valid bit, purely combinational.
REQ-031 Cell-occupied check SHALL be a 9:1 mux of pos1..pos9 on the latched select.

Verification
REQ-032 Reset, play=1 sel=5 board empty -> ply_En_pos=9'b000010000 for one cycle at t+2, XO_turn 1->0 at t+4, move_count=1.
REQ-033 pos3=01, play sel=3 -> illegal_move=1 one cycle at t+2, ply_En_pos=0, XO_turn and move_count unchanged.
REQ-034 play with sel=0 and sel=12 -> illegal_move pulse each, no write enable.
REQ-035 Nine legal alternating moves, win=0 -> game_over=1 after ninth UPDATE, move_count=9, further play ignored.
REQ-036 win=1 during UPDATE of third move -> game_over=1 next cycle; reset during COMMIT -> ply_En_pos=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: controller state encoding, cell codes and board size.
package ttt_pkg;

    localparam int NUM_POS = 9;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;
    localparam logic [1:0] CELL_BAD    = 2'b11;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_UPDATE,
        S_ILLEGAL,
        S_OVER
    } state_t;

endpackage

// File: rtl/pos_decoder.sv
// Combinational cell-select decoder: select value k (1..NUM_POS) drives one-hot bit k-1.
module pos_decoder #(
    parameter int NUM_POS = 9,
    parameter int SEL_W   = 4
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_POS-1:0] onehot,
    output logic               valid
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_POS; gi++) begin : g_dec
            assign onehot[gi] = (sel == SEL_W'(gi + 1));
        end
    endgenerate

    // Any out-of-range select (0 or above NUM_POS) leaves every bit low.
    assign valid = |onehot;

endmodule

// File: rtl/move_controller.sv
// Tic-tac-toe move controller: validates a requested cell, issues a one-cycle write
// enable, then advances turn and move count. Outputs are registered copies of state.
module move_controller #(
    parameter int NUM_POS = ttt_pkg::NUM_POS,
    parameter int SEL_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               play,
    input  logic [SEL_W-1:0]   pos_sel,
    input  logic [1:0]         pos1,
    input  logic [1:0]         pos2,
    input  logic [1:0]         pos3,
    input  logic [1:0]         pos4,
    input  logic [1:0]         pos5,
    input  logic [1:0]         pos6,
    input  logic [1:0]         pos7,
    input  logic [1:0]         pos8,
    input  logic [1:0]         pos9,
    input  logic               win,
    output logic [NUM_POS-1:0] ply_En_pos,
    output logic               XO_turn,
    output logic               illegal_move,
    output logic               game_over,
    output logic [3:0]         move_count
);

    import ttt_pkg::*;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic               turn_reg, turn_next;
    logic [3:0]         count_reg, count_next;

    logic [NUM_POS-1:0] dec_onehot;
    logic               dec_valid;
    logic [1:0]         cell_sel;
    logic               occupied;

    pos_decoder #(
        .NUM_POS (NUM_POS),
        .SEL_W   (SEL_W)
    ) u_pos_decoder (
        .sel    (sel_reg),
        .onehot (dec_onehot),
        .valid  (dec_valid)
    );

    always_comb begin
        cell_sel = CELL_EMPTY;
        case (sel_reg)
            SEL_W'(1): cell_sel = pos1;
            SEL_W'(2): cell_sel = pos2;
            SEL_W'(3): cell_sel = pos3;
            SEL_W'(4): cell_sel = pos4;
            SEL_W'(5): cell_sel = pos5;
            SEL_W'(6): cell_sel = pos6;
            SEL_W'(7): cell_sel = pos7;
            SEL_W'(8): cell_sel = pos8;
            SEL_W'(9): cell_sel = pos9;
            default:   cell_sel = CELL_EMPTY;
        endcase
    end

    // The unused code 11 is treated as taken so a corrupted cell is never overwritten.
    assign occupied = (cell_sel == CELL_PLAYER) || (cell_sel == CELL_COMP) ||
                      (cell_sel == CELL_BAD);

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        turn_next  = turn_reg;
        count_next = count_reg;
        case (state_reg)
            S_IDLE: begin
                if (win) begin
                    state_next = S_OVER;
                end else if (play) begin
                    sel_next   = pos_sel;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!dec_valid || occupied) begin
                    state_next = S_ILLEGAL;
                end else begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_next = S_UPDATE;
            end
            S_UPDATE: begin
                count_next = (count_reg >= MAX_MOVES) ? MAX_MOVES : count_reg + 4'd1;
                turn_next  = ~turn_reg;
                if (win || (count_next == MAX_MOVES)) begin
                    state_next = S_OVER;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ILLEGAL: begin
                state_next = S_IDLE;
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            sel_reg      <= '0;
            turn_reg     <= 1'b1;
            count_reg    <= 4'd0;
            ply_En_pos   <= '0;
            XO_turn      <= 1'b1;
            illegal_move <= 1'b0;
            game_over    <= 1'b0;
            move_count   <= 4'd0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            turn_reg     <= turn_next;
            count_reg    <= count_next;
            // Output stage trails the state register by one cycle.
            ply_En_pos   <= (state_reg == S_COMMIT) ? dec_onehot : '0;
            XO_turn      <= turn_reg;
            illegal_move <= (state_reg == S_ILLEGAL);
            game_over    <= (state_reg == S_OVER);
            move_count   <= count_reg;
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with hand-derived expectations and a small board model.
module tb_move_controller;

    localparam int NUM_POS = 9;
    localparam int SEL_W   = 4;

    logic               clock   = 1'b0;
    logic               reset   = 1'b0;
    logic               play    = 1'b0;
    logic               win     = 1'b0;
    logic [SEL_W-1:0]   pos_sel = '0;
    logic [1:0]         board [1:9];
    logic [NUM_POS-1:0] ply_En_pos;
    logic               XO_turn;
    logic               illegal_move;
    logic               game_over;
    logic [3:0]         move_count;

    int         checks = 0;
    int         errors = 0;
    logic       exp_turn;
    logic [3:0] exp_count;

    always #5 clock = ~clock;

    move_controller #(
        .NUM_POS (NUM_POS),
        .SEL_W   (SEL_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .play         (play),
        .pos_sel      (pos_sel),
        .pos1         (board[1]),
        .pos2         (board[2]),
        .pos3         (board[3]),
        .pos4         (board[4]),
        .pos5         (board[5]),
        .pos6         (board[6]),
        .pos7         (board[7]),
        .pos8         (board[8]),
        .pos9         (board[9]),
        .win          (win),
        .ply_En_pos   (ply_En_pos),
        .XO_turn      (XO_turn),
        .illegal_move (illegal_move),
        .game_over    (game_over),
        .move_count   (move_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_board;
        for (int i = 1; i <= 9; i++) board[i] = 2'b00;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        chk("rst_ply",     16'(ply_En_pos),   16'h0);
        chk("rst_turn",    16'(XO_turn),      16'h1);
        chk("rst_illegal", 16'(illegal_move), 16'h0);
        chk("rst_over",    16'(game_over),    16'h0);
        chk("rst_count",   16'(move_count),   16'h0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_turn  = 1'b1;
        exp_count = 4'd0;
        clear_board();
        $display("reset released");
    endtask

    // One request: play sampled at edge t, checks at t+1 .. t+4.
    task automatic move(input int sel, input bit ok, input bit hold, input bit win_flag);
        logic [8:0] oh;
        logic       t0;
        logic       exp_over;
        t0 = exp_turn;
        if (ok) oh = 9'(1 << (sel - 1));
        else    oh = '0;
        play    = 1'b1;
        pos_sel = 4'(sel);
        tick();                                  // edge t
        if (hold) pos_sel = 4'((sel % 9) + 1);
        else      play = 1'b0;
        tick();                                  // edge t+1
        chk("ply_t1",     16'(ply_En_pos),   16'h0);
        chk("illegal_t1", 16'(illegal_move), 16'h0);
        tick();                                  // edge t+2
        play = 1'b0;
        chk("ply_t2",     16'(ply_En_pos),   16'(oh));
        chk("illegal_t2", 16'(illegal_move), 16'(!ok));
        chk("turn_t2",    16'(XO_turn),      16'(t0));
        if (win_flag) win = 1'b1;
        tick();                                  // edge t+3
        win = 1'b0;
        chk("ply_t3",     16'(ply_En_pos),   16'h0);
        chk("illegal_t3", 16'(illegal_move), 16'h0);
        chk("turn_t3",    16'(XO_turn),      16'(t0));
        if (ok) begin
            exp_count  = (exp_count == 4'd9) ? 4'd9 : exp_count + 4'd1;
            exp_turn   = ~t0;
            board[sel] = t0 ? 2'b01 : 2'b10;
        end
        exp_over = ok && (win_flag || (exp_count == 4'd9));
        tick();                                  // edge t+4
        chk("turn_t4",  16'(XO_turn),    16'(exp_turn));
        chk("count_t4", 16'(move_count), 16'(exp_count));
        chk("over_t4",  16'(game_over),  16'(exp_over));
        $display("move sel=%0d legal=%0d turn=%0d count=%0d over=%0d",
                 sel, ok, XO_turn, move_count, game_over);
    endtask

    task automatic ignored_play(input int sel);
        play    = 1'b1;
        pos_sel = 4'(sel);
        repeat (4) begin
            tick();
            chk("over_ply",     16'(ply_En_pos),   16'h0);
            chk("over_illegal", 16'(illegal_move), 16'h0);
            chk("over_flag",    16'(game_over),    16'h1);
            chk("over_count",   16'(move_count),   16'(exp_count));
        end
        play = 1'b0;
        $display("play sel=%0d while over: ignored", sel);
    endtask

    initial begin
        clear_board();
        exp_turn  = 1'b1;
        exp_count = 4'd0;
        #2;
        do_reset();

        // Legal move on empty board, then occupied and out-of-range requests.
        move(5, 1'b1, 1'b0, 1'b0);
        board[3] = 2'b01;
        move(3, 1'b0, 1'b0, 1'b0);
        move(0, 1'b0, 1'b0, 1'b0);
        move(12, 1'b0, 1'b0, 1'b0);

        // play held high through the move must not queue a second request.
        move(1, 1'b1, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk("noqueue_ply",     16'(ply_En_pos),   16'h0);
            chk("noqueue_illegal", 16'(illegal_move), 16'h0);
        end
        chk("noqueue_count", 16'(move_count), 16'h2);

        // Reset while the write enable is visible aborts the move.
        play    = 1'b1;
        pos_sel = 4'd7;
        tick();
        play = 1'b0;
        tick();
        tick();
        chk("abort_ply_before", 16'(ply_En_pos), 16'h040);
        reset = 1'b1;
        #1;
        chk("abort_ply",   16'(ply_En_pos),   16'h0);
        chk("abort_count", 16'(move_count),   16'h0);
        chk("abort_turn",  16'(XO_turn),      16'h1);
        chk("abort_over",  16'(game_over),    16'h0);
        chk("abort_ill",   16'(illegal_move), 16'h0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_turn  = 1'b1;
        exp_count = 4'd0;
        clear_board();
        $display("reset during move applied");

        // Full board: nine alternating legal moves end the game.
        for (int s = 1; s <= 9; s++) move(s, 1'b1, 1'b0, 1'b0);
        board[1] = 2'b00;
        ignored_play(1);

        // Winner reported during the third move's update.
        do_reset();
        move(1, 1'b1, 1'b0, 1'b0);
        move(2, 1'b1, 1'b0, 1'b0);
        move(3, 1'b1, 1'b0, 1'b1);
        ignored_play(4);

        // Winner flag raised while idle.
        do_reset();
        win = 1'b1;
        tick();
        win = 1'b0;
        tick();
        chk("idlewin_over",  16'(game_over),  16'h1);
        chk("idlewin_count", 16'(move_count), 16'h0);
        chk("idlewin_turn",  16'(XO_turn),    16'h1);
        ignored_play(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
